// File: rtl/serial_adder.sv
// serial_adder: multi-cycle adder/subtractor that walks a WIDTH-bit operand
// pair through one DIGIT-bit ripple slice per clock, LSB slice first, with the
// slice carry registered between cycles.
//
// Ports:
//   clk, reset_n        rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready   operand handshake (in_ready high only in IDLE)
//   a, b, cin, sub      operands, carry/borrow-in, 0=add 1=subtract
//   out_valid/out_ready result handshake (out_valid high only in DONE)
//   sum, co, ovf        result, carry-out of MSB (sub: 1 = no borrow),
//                       two's-complement overflow; held until next completion
module serial_adder #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             ovf
);

  localparam int unsigned N     = WIDTH / DIGIT;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, stateNext;

  logic [WIDTH-1:0] aReg, bReg, resReg, resNext;
  logic             carryReg;
  logic [CNT_W-1:0] cnt;

  logic             accept, step, finish;
  logic [31:0]      sliceBase;
  logic [DIGIT-1:0] aSlice, bSlice, sliceSum;
  logic [DIGIT:0]   sliceFull;
  logic             sliceCarry, msbCarryIn;

  // State register; in_ready/out_valid are flopped decodes of the next state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= stateNext;
      in_ready  <= (stateNext == IDLE);
      out_valid <= (stateNext == DONE);
    end
  end

  // Next-state decode
  always_comb begin
    stateNext = state;
    accept    = 1'b0;
    step      = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          accept    = 1'b1;
          stateNext = BUSY;
        end
      end
      BUSY: begin
        step = 1'b1;
        if (cnt == LAST_SLICE) begin
          finish    = 1'b1;
          stateNext = DONE;
        end
      end
      DONE: begin
        if (out_ready) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // One DIGIT-bit ripple slice selected by the digit counter
  always_comb begin
    sliceBase  = 32'(cnt) * DIGIT;
    aSlice     = aReg[sliceBase +: DIGIT];
    bSlice     = bReg[sliceBase +: DIGIT];
    sliceFull  = {1'b0, aSlice} + {1'b0, bSlice} + (DIGIT + 1)'(carryReg);
    sliceSum   = sliceFull[DIGIT-1:0];
    sliceCarry = sliceFull[DIGIT];
    // Carry into the slice MSB recovered from its sum bit: c = s ^ a ^ b
    msbCarryIn = aSlice[DIGIT-1] ^ bSlice[DIGIT-1] ^ sliceSum[DIGIT-1];
    resNext    = resReg;
    resNext[sliceBase +: DIGIT] = sliceSum;
  end

  // Operand capture, slice accumulation and result load
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      aReg     <= '0;
      bReg     <= '0;
      resReg   <= '0;
      carryReg <= 1'b0;
      cnt      <= '0;
      sum      <= '0;
      co       <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      if (accept) begin
        aReg     <= a;
        bReg     <= b ^ {WIDTH{sub}};
        carryReg <= cin ^ sub;
        cnt      <= '0;
        resReg   <= '0;
      end
      if (step) begin
        resReg   <= resNext;
        carryReg <= sliceCarry;
        if (!finish) cnt <= cnt + CNT_W'(1);
      end
      if (finish) begin
        sum <= resNext;
        co  <= sliceCarry;
        ovf <= msbCarryIn ^ sliceCarry;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
`timescale 1ns/1ps
module tb_serial_adder;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic       inValid = 1'b0;
  logic       outReady = 1'b1;
  logic [7:0] a = '0, b = '0;
  logic       cin = 1'b0, sub = 1'b0;
  logic       sel = 1'b0;  // 0: DIGIT=1 instance, 1: DIGIT=4 instance

  logic       ir1, ov1, co1, of1, ir4, ov4, co4, of4;
  logic [7:0] s1, s4;

  serial_adder #(.WIDTH(8), .DIGIT(1)) u1 (
    .clk(clk), .reset_n(reset_n), .in_valid(inValid & ~sel), .in_ready(ir1),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(ov1), .out_ready(outReady),
    .sum(s1), .co(co1), .ovf(of1)
  );

  serial_adder #(.WIDTH(8), .DIGIT(4)) u4 (
    .clk(clk), .reset_n(reset_n), .in_valid(inValid & sel), .in_ready(ir4),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(ov4), .out_ready(outReady),
    .sum(s4), .co(co4), .ovf(of4)
  );

  wire       oReady = sel ? ir4 : ir1;
  wire       oValid = sel ? ov4 : ov1;
  wire [7:0] oSum   = sel ? s4 : s1;
  wire       oCo    = sel ? co4 : co1;
  wire       oOvf   = sel ? of4 : of1;

  typedef struct packed {
    logic [7:0] s;
    logic       c;
    logic       v;
  } exp_t;

  exp_t sb[$];
  int nVec = 0;
  int nMis = 0;

  // Reference: plain 9-bit arithmetic on the full word
  function automatic exp_t model(input logic [7:0] ia, input logic [7:0] ib,
                                 input logic icin, input logic isub);
    logic [7:0] be;
    logic [8:0] full;
    exp_t e;
    be   = ib ^ {8{isub}};
    full = {1'b0, ia} + {1'b0, be} + {8'd0, icin ^ isub};
    e.s  = full[7:0];
    e.c  = full[8];
    e.v  = (ia[7] == be[7]) && (full[7] != ia[7]);
    return e;
  endfunction

  // Called at a negedge with the selected DUT idle; returns at the next negedge
  task automatic acceptOp(input logic [7:0] ia, input logic [7:0] ib,
                          input logic icin, input logic isub);
    a = ia; b = ib; cin = icin; sub = isub; inValid = 1'b1;
    @(posedge clk);
    sb.push_back(model(ia, ib, icin, isub));
    @(negedge clk);
    inValid = 1'b0;
    a   = 8'($urandom);
    b   = 8'($urandom);
    cin = 1'($urandom);
    sub = 1'($urandom);
  endtask

  // Counts edges from accept until out_valid is seen (bounded)
  task automatic waitValid(output int lat);
    lat = 0;
    while (!oValid && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic runOp(input logic [7:0] ia, input logic [7:0] ib,
                       input logic icin, input logic isub,
                       output int lat, output exp_t e);
    acceptOp(ia, ib, icin, isub);
    waitValid(lat);
    if (sb.size() > 0) e = sb.pop_front();
    else e = '0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #12;
    nVec++; if (ir1 !== 1'b1) begin nMis++; $display("FAIL reset_in_ready1: got %b want 1", ir1); end
    nVec++; if (ov1 !== 1'b0) begin nMis++; $display("FAIL reset_out_valid1: got %b want 0", ov1); end
    nVec++; if ({s1, co1, of1} !== 10'd0) begin nMis++; $display("FAIL reset_result1: got %h/%b/%b want 00/0/0", s1, co1, of1); end
    nVec++; if (ir4 !== 1'b1) begin nMis++; $display("FAIL reset_in_ready4: got %b want 1", ir4); end
    nVec++; if (ov4 !== 1'b0) begin nMis++; $display("FAIL reset_out_valid4: got %b want 0", ov4); end
    nVec++; if ({s4, co4, of4} !== 10'd0) begin nMis++; $display("FAIL reset_result4: got %h/%b/%b want 00/0/0", s4, co4, of4); end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_add();
    logic [7:0] va [2];
    logic [7:0] vb [2];
    int lat;
    exp_t e;
    va[0] = 8'h3C; vb[0] = 8'h45;
    va[1] = 8'hFF; vb[1] = 8'h01;
    sel = 1'b0; outReady = 1'b1;
    for (int i = 0; i < 2; i++) begin
      runOp(va[i], vb[i], 1'b0, 1'b0, lat, e);
      nVec++; if (lat !== 8) begin nMis++; $display("FAIL add%0d_latency: got %0d want 8", i, lat); end
      nVec++; if (oSum !== e.s) begin nMis++; $display("FAIL add%0d_sum: got %h want %h", i, oSum, e.s); end
      nVec++; if ({oCo, oOvf} !== {e.c, e.v}) begin nMis++; $display("FAIL add%0d_co_ovf: got %b%b want %b%b", i, oCo, oOvf, e.c, e.v); end
      @(posedge clk); @(negedge clk);
      nVec++; if ({oValid, oReady} !== 2'b01) begin nMis++; $display("FAIL add%0d_idle: got valid/ready %b%b want 01", i, oValid, oReady); end
      nVec++; if (oSum !== e.s) begin nMis++; $display("FAIL add%0d_hold: got %h want %h", i, oSum, e.s); end
    end
  endtask

  task automatic test_sub();
    logic vc [2];
    int lat;
    exp_t e;
    vc[0] = 1'b0; vc[1] = 1'b1;
    sel = 1'b0; outReady = 1'b1;
    for (int i = 0; i < 2; i++) begin
      runOp(8'h10, 8'h20, vc[i], 1'b1, lat, e);
      nVec++; if (lat !== 8) begin nMis++; $display("FAIL sub%0d_latency: got %0d want 8", i, lat); end
      nVec++; if (oSum !== e.s) begin nMis++; $display("FAIL sub%0d_sum: got %h want %h", i, oSum, e.s); end
      nVec++; if ({oCo, oOvf} !== {e.c, e.v}) begin nMis++; $display("FAIL sub%0d_co_ovf: got %b%b want %b%b", i, oCo, oOvf, e.c, e.v); end
      @(posedge clk); @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    exp_t e;
    sel = 1'b0; outReady = 1'b0;
    runOp(8'h5A, 8'h33, 1'b1, 1'b0, lat, e);
    nVec++; if (lat !== 8) begin nMis++; $display("FAIL bp_latency: got %0d want 8", lat); end
    nVec++; if ({oSum, oCo, oOvf} !== {e.s, e.c, e.v}) begin nMis++; $display("FAIL bp_result: got %h/%b/%b want %h/%b/%b", oSum, oCo, oOvf, e.s, e.c, e.v); end
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); @(negedge clk);
      nVec++; if ({oValid, oReady} !== 2'b10) begin nMis++; $display("FAIL bp_stall%0d_hs: got valid/ready %b%b want 10", k, oValid, oReady); end
      nVec++; if ({oSum, oCo, oOvf} !== {e.s, e.c, e.v}) begin nMis++; $display("FAIL bp_stall%0d_stable: got %h/%b/%b want %h/%b/%b", k, oSum, oCo, oOvf, e.s, e.c, e.v); end
    end
    outReady = 1'b1;
    @(posedge clk); @(negedge clk);
    nVec++; if ({oValid, oReady} !== 2'b01) begin nMis++; $display("FAIL bp_release: got valid/ready %b%b want 01", oValid, oReady); end
    runOp(8'h12, 8'h34, 1'b0, 1'b0, lat, e);
    nVec++; if (lat !== 8) begin nMis++; $display("FAIL bp_next_latency: got %0d want 8", lat); end
    nVec++; if ({oSum, oCo, oOvf} !== {e.s, e.c, e.v}) begin nMis++; $display("FAIL bp_next_result: got %h/%b/%b want %h/%b/%b", oSum, oCo, oOvf, e.s, e.c, e.v); end
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int lat;
    exp_t e;
    sel = 1'b0; outReady = 1'b1;
    acceptOp(8'hA5, 8'h5A, 1'b0, 1'b0);
    @(posedge clk); @(posedge clk); @(negedge clk);
    reset_n = 1'b0;
    #1;
    nVec++; if ({ir1, ov1} !== 2'b10) begin nMis++; $display("FAIL rstmid_hs: got ready/valid %b%b want 10", ir1, ov1); end
    nVec++; if ({s1, co1, of1} !== 10'd0) begin nMis++; $display("FAIL rstmid_result: got %h/%b/%b want 00/0/0", s1, co1, of1); end
    sb.delete();
    @(negedge clk);
    reset_n = 1'b1;
    runOp(8'h01, 8'h01, 1'b0, 1'b0, lat, e);
    nVec++; if (lat !== 8) begin nMis++; $display("FAIL rstmid_latency: got %0d want 8", lat); end
    nVec++; if ({oSum, oCo, oOvf} !== {e.s, e.c, e.v}) begin nMis++; $display("FAIL rstmid_after: got %h/%b/%b want %h/%b/%b", oSum, oCo, oOvf, e.s, e.c, e.v); end
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_digit4();
    int lat;
    exp_t e;
    sel = 1'b1; outReady = 1'b1;
    runOp(8'h7F, 8'h01, 1'b0, 1'b0, lat, e);
    nVec++; if (lat !== 2) begin nMis++; $display("FAIL d4_latency: got %0d want 2", lat); end
    nVec++; if ({oSum, oCo, oOvf} !== {e.s, e.c, e.v}) begin nMis++; $display("FAIL d4_result: got %h/%b/%b want %h/%b/%b", oSum, oCo, oOvf, e.s, e.c, e.v); end
    @(posedge clk); @(negedge clk);
    nVec++; if ({oValid, oReady} !== 2'b01) begin nMis++; $display("FAIL d4_idle: got valid/ready %b%b want 01", oValid, oReady); end
    sel = 1'b0;
  endtask

  // Random operations with out_ready held high: each accept lands at E(N+2)
  task automatic test_back_to_back();
    int lat;
    int wantLat;
    exp_t e;
    outReady = 1'b1;
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      wantLat = (s == 0) ? 8 : 2;
      for (int i = 0; i < 6; i++) begin
        runOp(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), lat, e);
        nVec++; if (lat !== wantLat) begin nMis++; $display("FAIL b2b_s%0d_op%0d_latency: got %0d want %0d", s, i, lat, wantLat); end
        nVec++; if ({oSum, oCo, oOvf} !== {e.s, e.c, e.v}) begin nMis++; $display("FAIL b2b_s%0d_op%0d_result: got %h/%b/%b want %h/%b/%b", s, i, oSum, oCo, oOvf, e.s, e.c, e.v); end
        @(posedge clk); @(negedge clk);
        nVec++; if (oReady !== 1'b1) begin nMis++; $display("FAIL b2b_s%0d_op%0d_ready: got %b want 1", s, i, oReady); end
      end
    end
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_backpressure();
    test_reset_mid();
    test_digit4();
    test_back_to_back();
    nVec++; if (sb.size() != 0) begin nMis++; $display("FAIL scoreboard_leftover: got %0d want 0", sb.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised multi-cycle adder/subtractor that processes a WIDTH-bit operand pair DIGIT bits per clock through a single DIGIT-bit ripple full-adder slice. Each cycle's carry is registered into the next cycle. Two operands plus carry-in are accepted over a valid/ready input handshake, and sum, carry-out and signed overflow are returned over a valid/ready output handshake. It is the area-optimised successor to the combinational full adder and serves as the arithmetic unit for datapaths where latency is cheaper than gates.

## Interface
- WIDTH, 8, operand and result width in bits; must be ≥ 2.
- DIGIT, 1, bits processed per cycle; must divide WIDTH exactly.
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands present.
- in_ready  output  1  block can accept operands; high only in IDLE.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in (add) or borrow-in (sub).
- sub  input  1  0 = add, 1 = subtract.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result.
- co  output  1  carry-out of MSB; for subtract, 1 = no borrow.
- ovf  output  1  two's-complement overflow.

## Operation
- N = WIDTH/DIGIT.
- States are IDLE, BUSY and DONE.
- IDLE: in_ready=1. When in_valid=1 at a clock edge:
  - Latch a, and latch b_eff = b XOR {WIDTH{sub}}.
  - Load the carry register with cin XOR sub.
  - Clear the digit counter and go to BUSY.
- sub=1, cin=0 computes a−b. sub=1, cin=1 computes a−b−1.
- BUSY, each edge:
  - Add the current DIGIT-bit slice of a and b_eff (LSB slice first) plus the carry register.
  - Store the slice result into the internal shift/result register.
  - Update the carry register and increment the counter.
  - After the N-th slice, go to DONE.
- On the IDLE→BUSY transition... completion loads the outputs: on the BUSY→DONE transition, load sum, co and ovf in the same edge.
  - co = carry out of bit WIDTH−1.
  - ovf = carry into bit WIDTH−1 XOR carry out of bit WIDTH−1.
  - When DIGIT>1, the carry into the MSB is taken from inside the final slice.
- DONE: out_valid=1. sum, co and ovf stay stable until out_valid & out_ready at an edge, then go to IDLE.
- sum, co and ovf hold their last value after the handshake. They change only on the next BUSY→DONE transition.
- Inputs a, b, cin and sub are ignored outside the accepting edge. Changing them during BUSY has no effect.
- in_ready=0 in DONE, so in_valid is never accepted in the same cycle a result is consumed.
- Illegal or unreachable state encodings go to IDLE.

## Timing
- Reset (reset_n low, asynchronous):
  - State goes to IDLE, counter and carry register clear.
  - Outputs: in_ready=1, out_valid=0, sum=0, co=0, ovf=0.
- Reset asserted in BUSY or DONE aborts the operation. No out_valid is produced and the in-flight result is discarded.
- Deassertion of reset_n is synchronised externally. The first accept is allowed at the first edge with reset_n high.
- Latency:
  - Accept edge is E0.
  - Slices are computed at E1..EN.
  - out_valid is high from just after EN.
  - This gives N cycles from accept to out_valid.
- Throughput:
  - With out_ready held high, the result is consumed at E(N+1) and the block is in IDLE.
  - The next accept is possible at E(N+2).
  - Minimum period is N+2 cycles per operation.
- Backpressure: out_valid stays asserted and sum, co and ovf do not change for any number of cycles out_ready=0.
- in_ready and out_valid are registered-state decodes, with no combinational path from in_valid or out_ready.

## Test plan
- Add, WIDTH=8, DIGIT=1: a=0x3C, b=0x45, cin=0, sub=0 -> out_valid 8 cycles after accept; sum=0x81, co=0, ovf=1.
- Wrap: a=0xFF, b=0x01, cin=0, sub=0 -> sum=0x00, co=1, ovf=0.
- Subtract: a=0x10, b=0x20, cin=0, sub=1 -> sum=0xF0, co=0 (borrow), ovf=0. Repeat with cin=1 -> sum=0xEF, co=0.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> out_valid, sum and co stable throughout, and in_ready=0. out_ready=1 gives IDLE next edge and accept two edges later.
- DIGIT=4, WIDTH=8: a=0x7F, b=0x01 -> out_valid 2 cycles after accept; sum=0x80, co=0, ovf=1.
- Reset mid-operation: pull reset_n low during the 3rd BUSY cycle -> in_ready=1, out_valid=0, sum=0 immediately. After release, a fresh 0x01+0x01 gives sum=0x02 after 8 cycles.
